rv_uart_tx: RTL and testbench

RV_UART_TX -- requirements
Module: rv_uart_tx

---
 rtl/rv_mmio_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/rv_uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_rv_uart_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mmio_pkg.sv
// Shared definitions for the MMIO UART transmitter: register word offsets, STATUS bit indices, FSM states.
// Optional build macro: RV_UART_PARITY_EN adds the PARITY state.
package rv_mmio_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RV_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    // A programmed divisor of zero still yields one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; DEPTH must be a power of two.
// A push while full succeeds when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUDDIV window, TX FIFO, 8N1 framing.
// Optional build macro: RV_UART_PARITY_EN inserts an even-parity bit (8E1).
module rv_uart_tx
    import rv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemdatain,
    input  logic [2:0]  dmemop,
    input  logic        dmemwe,
    output logic [31:0] dmemdataout,
    output logic        sel,
    output logic        txd
);

    tx_state_t   state, state_n;
    logic [15:0] bauddiv;
    logic [15:0] div_lat, div_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        txd_n;
    logic        overflow;
    logic        bit_done;
    logic        push, pop;
    logic        full, empty;
    logic [7:0]  fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [1:0]  off;
    logic        wr;
    logic        busy;
`ifdef RV_UART_PARITY_EN
    logic        parity, parity_n;
`endif

    assign sel  = (dmemaddr[31:4] == BASE_ADDR[31:4]);
    assign off  = dmemaddr[3:2];
    assign wr   = dmemwe && sel;
    assign push = wr && (off == REG_TXDATA);
    assign busy = (state != ST_IDLE);

    logic unused_bits;
    assign unused_bits = ^{dmemop, dmemaddr[1:0], dmemdatain[31:16], fifo_count};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (dmemdatain[7:0]),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        dmemdataout = '0;
        if (sel) begin
            case (off)
                REG_STATUS: begin
                    dmemdataout[STAT_FULL]  = full;
                    dmemdataout[STAT_EMPTY] = empty;
                    dmemdataout[STAT_BUSY]  = busy;
                    dmemdataout[STAT_OVF]   = overflow;
                end
                REG_BAUDDIV: dmemdataout[15:0] = bauddiv;
                default:     dmemdataout = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bauddiv  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr && (off == REG_BAUDDIV)) begin
                bauddiv <= dmemdatain[15:0];
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (wr && (off == REG_STATUS) && dmemdatain[STAT_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bit_done = (baud_cnt == eff_div(div_lat) - 16'd1);

    // txd is registered from the next-state decision so START goes low on the popping edge.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        div_n    = div_lat;
        baud_n   = baud_cnt + 16'd1;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        txd_n    = txd;
`ifdef RV_UART_PARITY_EN
        parity_n = parity;
`endif
        case (state)
            ST_IDLE: begin
                baud_n = '0;
                txd_n  = 1'b1;
                if (!empty) begin
                    state_n = ST_START;
                    pop     = 1'b1;
                    div_n   = bauddiv;
                    shreg_n = fifo_rdata;
                    txd_n   = 1'b0;
`ifdef RV_UART_PARITY_EN
                    parity_n = ^fifo_rdata;
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_n = ST_DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                    txd_n   = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef RV_UART_PARITY_EN
                        state_n = ST_PARITY;
                        txd_n   = parity;
`else
                        state_n = ST_STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        txd_n   = shreg[1];
                    end
                end
            end
`ifdef RV_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_n = ST_STOP;
                    baud_n  = '0;
                    txd_n   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (!empty) begin
                        state_n = ST_START;
                        pop     = 1'b1;
                        div_n   = bauddiv;
                        shreg_n = fifo_rdata;
                        txd_n   = 1'b0;
`ifdef RV_UART_PARITY_EN
                        parity_n = ^fifo_rdata;
`endif
                    end else begin
                        state_n = ST_IDLE;
                        txd_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                baud_n  = '0;
                txd_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            div_lat  <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
`ifdef RV_UART_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            div_lat  <= div_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            txd      <= txd_n;
`ifdef RV_UART_PARITY_EN
            parity   <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_rv_uart_tx.sv
// Scoreboard bench for rv_uart_tx: stores queue expected frames, a txd monitor decodes and checks them.
// Honours RV_UART_PARITY_EN for the expected frame shape.
module tb_rv_uart_tx;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_BD = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;
`ifdef RV_UART_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemdatain = '0;
    logic [2:0]  dmemop = 3'b010;
    logic        dmemwe = 1'b0;
    logic [31:0] dmemdataout;
    logic        sel;
    logic        txd;

    typedef struct {
        logic [7:0]  data;
        int unsigned div;
        bit          b2b;
    } exp_t;

    exp_t q[$];
    bit   in_frame = 1'b0;
    int   checks = 0;
    int   fails = 0;

    rv_uart_tx #(
        .BASE_ADDR   (32'h0010_0000),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .dmemaddr    (dmemaddr),
        .dmemdatain  (dmemdatain),
        .dmemop      (dmemop),
        .dmemwe      (dmemwe),
        .dmemdataout (dmemdataout),
        .sel         (sel),
        .txd         (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        dmemaddr   = addr;
        dmemdatain = data;
        dmemwe     = 1'b1;
        @(posedge clk);
        #1;
        dmemwe     = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        dmemaddr = addr;
        dmemwe   = 1'b0;
        #1;
        data = dmemdataout;
    endtask

    task automatic send(input logic [7:0] data, input int unsigned div, input bit b2b);
        exp_t e;
        e.data = data;
        e.div  = div;
        e.b2b  = b2b;
        q.push_back(e);
        wr(A_TX, {24'h0, data});
    endtask

    task automatic wait_drain(input int unsigned budget);
        for (int unsigned i = 0; i < budget && (q.size() != 0 || in_frame); i++) begin
            @(posedge clk);
        end
        chk("drain", {31'h0, (q.size() != 0 || in_frame)}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: samples txd on falling edges, checks every clock of every bit against the queued frame.
    initial begin : monitor
        exp_t        cur;
        logic [10:0] bits;
        logic [10:0] badmask;
        int unsigned nbits, bidx, cyc, gap;
        bit          skip;
        cur = '{data: 8'h00, div: 1, b2b: 1'b0};
        bits = '0; badmask = '0; nbits = 0; bidx = 0; cyc = 0; gap = 1000; skip = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                in_frame = 1'b0;
                skip     = 1'b0;
                gap      = 1000;
            end else begin
                if (skip) begin
                    if (txd === 1'b1) skip = 1'b0;
                end else if (!in_frame) begin
                    if (txd === 1'b0) begin
                        if (q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL unexpected_frame: txd low, expected idle high");
                            skip = 1'b1;
                        end else begin
                            cur = q.pop_front();
                            if (cur.b2b) begin
                                checks++;
                                if (gap != 0) begin
                                    fails++;
                                    $display("FAIL b2b_gap %h: got %0d idle cycles, expected 0", cur.data, gap);
                                end
                            end
                            bits = '1;
                            bits[0] = 1'b0;
                            for (int i = 0; i < 8; i++) bits[1+i] = cur.data[i];
`ifdef RV_UART_PARITY_EN
                            bits[9] = ^cur.data;
                            nbits = 11;
`else
                            nbits = 10;
`endif
                            in_frame = 1'b1;
                            bidx = 0;
                            cyc = 0;
                            badmask = '0;
                        end
                    end else begin
                        gap++;
                    end
                end
                if (in_frame) begin
                    if (txd !== bits[bidx]) badmask[bidx] = 1'b1;
                    cyc++;
                    if (cyc == cur.div) begin
                        cyc = 0;
                        bidx++;
                        if (bidx == nbits) begin
                            checks++;
                            if (badmask != '0) begin
                                fails++;
                                $display("FAIL frame %h div %0d: bad-bit mask got %b, expected 0", cur.data, cur.div, badmask);
                            end
                            in_frame = 1'b0;
                            gap = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] v;
        int unsigned lows;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_txd", {31'h0, txd}, 32'h1);
        reset = 1'b0;
        rd(A_ST, v); chk("reset_status", v, 32'h2);
        rd(A_BD, v); chk("reset_bauddiv", v, 32'd434);
        rd(A_TX, v); chk("txdata_reads_0", v, 32'h0);
        chk("sel_hit", {31'h0, sel}, 32'h1);
        rd(BASE + 32'h10, v); chk("sel_miss", {31'h0, sel}, 32'h0);

        // Unselected store and reserved store have no effect
        wr(32'h0020_0000, 32'h0000_00AA);
        wr(A_RS, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        rd(A_ST, v); chk("unselected_store_ignored", v, 32'h2);
        rd(A_RS, v); chk("reserved_reads_0", v, 32'h0);
        chk("idle_txd", {31'h0, txd}, 32'h1);

        // Single 0x55 frame at DIV=4 with busy timing
        wr(A_BD, 32'd4);
        rd(A_BD, v); chk("bauddiv_rw", v, 32'd4);
        send(8'h55, 4, 1'b0);
        repeat (FRAME_BITS * 4) @(posedge clk);
        rd(A_ST, v); chk("busy_last_cycle", {31'h0, v[2]}, 32'h1);
        @(posedge clk);
        rd(A_ST, v); chk("busy_cleared", v, 32'h2);
        wait_drain(200);

        // Two bytes back-to-back
        send(8'h41, 4, 1'b0);
        send(8'h42, 4, 1'b1);
        wait_drain(300);

        // Divisor change mid-frame applies to next frame only
        send(8'h3C, 4, 1'b0);
        send(8'hA5, 8, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        wr(A_BD, 32'd8);
        rd(A_BD, v); chk("bauddiv_mid_frame", v, 32'd8);
        wait_drain(400);

        // Fill and overflow at DIV=2
        wr(A_BD, 32'd2);
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 2, (i != 0));
        rd(A_ST, v); chk("full_after_9th", v, 32'h5);
        wr(A_TX, 32'h0000_0019);
        rd(A_ST, v); chk("overflow_set", v, 32'hD);
        wr(A_ST, 32'h0000_0007);
        rd(A_ST, v); chk("overflow_sticky", v, 32'hD);
        wr(A_ST, 32'h0000_0008);
        rd(A_ST, v); chk("overflow_cleared", v, 32'h5);
        wait_drain(600);

        // DIV=1 and DIV=0 (treated as 1)
        wr(A_BD, 32'd1);
        send(8'h07, 1, 1'b0);
        repeat (FRAME_BITS) @(posedge clk);
        rd(A_ST, v); chk("div1_busy_last", {31'h0, v[2]}, 32'h1);
        @(posedge clk);
        rd(A_ST, v); chk("div1_frame_len", v, 32'h2);
        wait_drain(50);
        wr(A_BD, 32'd0);
        rd(A_BD, v); chk("bauddiv_zero_rw", v, 32'd0);
        send(8'hC3, 1, 1'b0);
        repeat (FRAME_BITS) @(posedge clk);
        rd(A_ST, v); chk("div0_busy_last", {31'h0, v[2]}, 32'h1);
        @(posedge clk);
        rd(A_ST, v); chk("div0_frame_len", v, 32'h2);
        wait_drain(50);

        // Reset during data bit 3 with a second byte queued
        wr(A_BD, 32'd4);
        send(8'hF0, 4, 1'b0);
        send(8'h0F, 4, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_txd", {31'h0, txd}, 32'h1);
        rd(A_ST, v); chk("abort_status", v, 32'h2);
        rd(A_BD, v); chk("abort_bauddiv", v, 32'd434);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("abort_stays_idle", lows, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
